uram_stream_reader: RTL and testbench
=====================================

// Module: uram_stream_reader
// PURPOSE
//  Read-side client for the 16-bit, 2-cycle-read-latency URAM scratchpad wrapper.
//  Takes a (base, length) burst command, issues one read per cycle on the wrapper's read port,
//  and delivers the returned words as a valid/ready stream. An internal credit-checked FIFO
//  absorbs the fixed read latency, so downstream backpressure never drops in-flight data.
// PARAMETERS
//  ADDRESS_WIDTH  14  word-address width; must match the URAM wrapper
//  READ_LATENCY   2   raddr-to-rdata latency of the memory, in cycles
//  FIFO_DEPTH     4   output buffer entries; must be >= READ_LATENCY+1 (full-rate requirement)
// PORTS
//  clock      in   1                single clock
//  reset_n    in   1                synchronous reset, active-low
//  start      in   1                command strobe; sampled only in IDLE
//  base_addr  in   ADDRESS_WIDTH    first word address of the burst
//  length     in   ADDRESS_WIDTH+1  number of words; 0 is legal
//  busy       out  1                high from the cycle after an accepted start until done
//  done       out  1                one-cycle pulse when a burst completes
//  mem_raddr  out  ADDRESS_WIDTH    drives the memory raddr
//  mem_rdata  in   16               memory dout
//  out_valid  out  1                stream word valid
//  out_ready  in   1                stream consumer ready
//  out_data   out  16               stream word
//  out_last   out  1                qualifies the final word of a burst
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge):
//  - State -> IDLE; busy, done, out_valid, out_last = 0; out_data = 0; mem_raddr = 0.
//  - Clears FIFO, in-flight tracker, and counters. Any burst in progress is aborted silently; no done.
//  FSM states: IDLE, ISSUE, DRAIN.
//  - IDLE, start=1, length!=0: latch base and length, go to ISSUE.
//  - IDLE, start=1, length=0: done=1 in the next cycle, stay IDLE, busy stays 0.
//  - start while not IDLE: ignored.
//  - ISSUE, read fire: the cycle's read fires when
//    in_flight + fifo_count - (out_valid & out_ready) < FIFO_DEPTH.
//    mem_raddr = current address register, which increments by 1 per fire.
//  - ISSUE, wrap-around: addresses wrap modulo 2^ADDRESS_WIDTH.
//  - ISSUE -> DRAIN: in the cycle the last read fires.
//  - In-flight tracking: a READ_LATENCY-deep valid shift register marks fired reads.
//    mem_rdata is written into the FIFO exactly READ_LATENCY cycles after its fire.
//    The credit rule guarantees this write never overflows the FIFO.
//  - mem_raddr when no fire: holds its value; the memory's read is harmless.
//  - DRAIN -> IDLE: on the handshake of the word with out_last=1. done=1 in the following cycle.
//  Stream handshake:
//  - Standard valid/ready; a transfer occurs when both are high at a clock edge.
//  - out_valid = FIFO non-empty, registered output.
//  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
//  - out_valid does not depend combinationally on out_ready.
//  - Simultaneous FIFO push and pop are allowed, including when the FIFO is full
//    (pop frees the slot) and when it is empty (data appears next cycle).
//  Latency: start sampled in cycle t:
//  - First fire in t+1.
//  - out_valid first high in t+2+READ_LATENCY.
//  - Sustained 1 word/cycle while out_ready=1.
//  Width rules:
//  - length up to 2^ADDRESS_WIDTH (a full sweep) is legal.
//  - Counters are ADDRESS_WIDTH+1 bits; no truncation.
// TESTING
//  1. mem[0x10..0x13]=A,B,C,D; start base=0x10 len=4, out_ready=1 -> A,B,C,D in t+4..t+7;
//     out_last only on D; done=1 at t+8.
//  2. Same burst, out_ready=0 for 10 cycles after start -> at most FIFO_DEPTH reads fired;
//     on release, A..D in order, none lost or duplicated.
//  3. base=0x3FFE len=4 (ADDRESS_WIDTH=14) -> mem_raddr sequence 3FFE,3FFF,0000,0001.
//  4. start with len=0 -> done pulse next cycle, busy=0, out_valid never asserted.
//  5. reset_n=0 mid-burst (2 words delivered) -> all outputs 0 next cycle, no done.
//     A fresh burst then returns the correct data.
//  6. Random out_ready, len=1000 -> output equals the memory contents, in order; busy low after done.

Source files
------------

// File: rtl/uram_stream_reader_if.sv
// Valid/ready word stream out of the URAM reader.
// master drives valid/data/last, slave drives ready.
interface uram_stream_reader_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;
  logic        last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/uram_stream_reader.sv
// Burst reader: one read per cycle into a credit-checked FIFO.
// Ports: clock/reset_n, start/base_addr/length cmd, busy/done,
// mem_raddr/mem_rdata memory port, stream valid/ready output.
module uram_stream_reader #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [15:0]              mem_rdata,
  uram_stream_reader_if.master     stream
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam int PW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + RL + 1);
  localparam logic [AW:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     rem_q;
  logic [RL-1:0]   fly_q;
  logic [RL-1:0]   fly_last_q;
  logic [16:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;

  logic            fire;
  logic            push;
  logic            pop;
  logic            head_last;
  logic            zero_cmd;
  logic [OW-1:0]   infl;
  logic [OW-1:0]   occ;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ?
           '0 : p + PW'(1);
  endfunction

  assign push         = fly_q[RL-1];
  assign pop          = stream.valid & stream.ready;
  assign head_last    = fifo_q[rd_q][16];
  assign stream.valid = (cnt_q != '0);
  assign stream.data  = stream.valid ?
                        fifo_q[rd_q][15:0] : '0;
  assign stream.last  = stream.valid & head_last;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign mem_raddr    = addr_q;

  // Occupancy after this edge if nothing new fires:
  // reads still in the memory pipe plus buffered words.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RL; i++)
      infl = infl + OW'(fly_q[i]);
    occ = infl + OW'(cnt_q) - OW'(pop);
  end

  always_comb begin
    state_d  = state_q;
    fire     = 1'b0;
    zero_cmd = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0)
            zero_cmd = 1'b1;
          else
            state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (occ < OW'(FIFO_DEPTH)) begin
          fire = 1'b1;
          if (rem_q == ONE)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      fly_q      <= '0;
      fly_last_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= zero_cmd |
                 ((state_q == DRAIN) & pop & head_last);

      if (state_q == IDLE && state_d == ISSUE) begin
        addr_q <= base_addr;
        rem_q  <= length;
      end else if (fire) begin
        addr_q <= addr_q + AW'(1);
        rem_q  <= rem_q - ONE;
      end

      // The last flag rides with its read through the pipe.
      fly_q[0]      <= fire;
      fly_last_q[0] <= fire && (rem_q == ONE);
      for (int i = 1; i < RL; i++) begin
        fly_q[i]      <= fly_q[i-1];
        fly_last_q[i] <= fly_last_q[i-1];
      end

      if (push) begin
        fifo_q[wr_q] <= {fly_last_q[RL-1], mem_rdata};
        wr_q         <= nxt(wr_q);
      end
      if (pop)
        rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_uram_stream_reader.sv
// Directed bench for uram_stream_reader with a
// 2-cycle memory model and in-order stream checks.
module tb_uram_stream_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic        busy;
  logic        done;
  logic [13:0] mem_raddr;
  logic [15:0] mem_rdata;

  uram_stream_reader_if stream ();

  uram_stream_reader #(
    .ADDRESS_WIDTH (14),
    .READ_LATENCY  (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .stream    (stream)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [16384];
  logic [15:0] r1;

  always @(posedge clock) begin
    r1        <= mem[mem_raddr];
    mem_rdata <= r1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic burst(input logic [13:0] b,
                       input logic [14:0] n,
                       input int stall,
                       input bit rnd,
                       input int limit);
    int          idx;
    int          first_v;
    int          done_c;
    logic        got;
    logic [13:0] a;
    base_addr = b;
    length    = n;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    idx     = 0;
    got     = 1'b0;
    first_v = -1;
    done_c  = -1;
    for (int c = 0; c < limit && !got; c++) begin
      if (c < stall)
        stream.ready = 1'b0;
      else if (rnd)
        stream.ready = 1'($urandom_range(0, 1));
      else
        stream.ready = 1'b1;
      if (c == 0)
        chk("busy_on", busy, 1);
      if (c < 4) begin
        a = b + 14'(c);
        chk("raddr", mem_raddr, a);
      end
      if (stall > 0 && c == stall - 1) begin
        a = b + 14'(4);
        chk("credit_stall", mem_raddr, a);
      end
      if (done) begin
        got    = 1'b1;
        done_c = c;
      end else if (stream.valid) begin
        if (first_v < 0)
          first_v = c;
        if (stream.ready) begin
          a = b + 14'(idx);
          chk("data", stream.data, mem[a]);
          chk("last", stream.last, idx == n - 1);
          idx++;
        end
      end
      if (!got)
        tick();
    end
    chk("word_count", idx, n);
    chk("done_seen", got, 1);
    chk("busy_off", busy, 0);
    if (stall == 0 && !rnd) begin
      chk("first_valid", first_v, 3);
      chk("done_time", done_c, n + 3);
    end
    tick();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int idx;
    for (int i = 0; i < 16384; i++)
      mem[i] = 16'(i * 32'h9E37) ^ 16'hC3A5;

    reset_n      = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    stream.ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", stream.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_data", stream.data, 0);
    chk("rst_last", stream.last, 0);
    reset_n = 1'b1;
    tick();

    burst(14'h0010, 15'd4, 0, 1'b0, 20);
    burst(14'h0010, 15'd6, 10, 1'b0, 40);
    burst(14'h3FFE, 15'd4, 0, 1'b0, 20);

    length    = '0;
    base_addr = 14'h0055;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("zlen_done", done, 1);
    chk("zlen_busy", busy, 0);
    chk("zlen_valid", stream.valid, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("zlen_idle_done", done, 0);
      chk("zlen_idle_valid", stream.valid, 0);
    end

    base_addr    = 14'h0020;
    length       = 15'd8;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    stream.ready = 1'b1;
    idx          = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      if (stream.valid)
        idx++;
      if (idx < 2)
        tick();
    end
    chk("mid_words", idx, 2);
    reset_n = 1'b0;
    tick();
    chk("mid_valid", stream.valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_raddr", mem_raddr, 0);
    chk("mid_data", stream.data, 0);
    chk("mid_last", stream.last, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", stream.valid, 0);
    end
    burst(14'h0040, 15'd5, 0, 1'b0, 30);

    burst(14'h0100, 15'd1000, 0, 1'b1, 6000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
